// File: rtl/fetch_stall_controller.sv
// Fetch-side consumer of the hazard-detection controls: owns PC, IF/ID and the ID/EX valid bit,
// and keeps a pipeline-state FSM, saturating stall/flush counters and sticky debug flags.
module fetch_stall_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             PC_Write,
    input  logic             IF_ID_Write,
    input  logic             PC_Src,
    input  logic             Jump,
    input  logic             JmpandLink,
    input  logic             isJr,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      JumpTarget,
    input  logic [31:0]      JrTarget,
    input  logic [31:0]      Instr_In,
    output logic [31:0]      PC,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic             ID_EXE_Valid,
    output logic [1:0]       PipeState,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic             Protocol_Err,
    output logic             Align_Err,
    output logic             Stall_Timeout
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } pipe_state_e;

    // The run counter only needs to reach MAX_STALL+1; it parks there once the timeout fires.
    localparam int               RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    pipe_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic        redirect;
    logic        hold_cycle;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;

    assign redirect   = PC_Src | Jump | JmpandLink | isJr;
    assign hold_cycle = ~PC_Write & ~redirect;
    assign pc_plus4   = PC + 32'd4;

    always_comb begin
        redirect_target = JumpTarget;
        if (PC_Src)
            redirect_target = BranchTarget;
        else if (isJr)
            redirect_target = JrTarget;
    end

    assign next_pc = redirect ? {redirect_target[31:2], 2'b00} : {pc_plus4[31:2], 2'b00};

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_FILL)
            state_d = ST_RUN;
        else if (redirect)
            state_d = ST_FLUSH;
        else if (!PC_Write)
            state_d = ST_STALL;
        else
            state_d = ST_RUN;
    end

    always_comb begin
        run_d = '0;
        if (hold_cycle)
            run_d = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
    end

    assign PipeState = state_q;

    // NOTE: reset is synchronous and covers every register here, including in-flight IF/ID contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            run_q         <= '0;
            PC            <= RESET_PC;
            IF_ID_Instr   <= '0;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
            ID_EXE_Valid  <= 1'b0;
            StallCycles   <= '0;
            FlushCount    <= '0;
            Protocol_Err  <= 1'b0;
            Align_Err     <= 1'b0;
            Stall_Timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q      <= state_d;
            run_q        <= run_d;
            ID_EXE_Valid <= IF_ID_Valid & ~Stall;

            if (PC_Write || redirect)
                PC <= next_pc;

            // A redirect squashes the wrong-path fetch even when the hazard unit asked to hold IF/ID.
            if (redirect) begin
                IF_ID_Instr <= '0;
                IF_ID_Valid <= 1'b0;
            end else if (IF_ID_Write) begin
                IF_ID_Instr   <= Instr_In;
                IF_ID_PCPlus4 <= pc_plus4;
                IF_ID_Valid   <= 1'b1;
            end

            if (hold_cycle && StallCycles != CNT_MAX)
                StallCycles <= StallCycles + CNT_W'(1);
            if (redirect && FlushCount != CNT_MAX)
                FlushCount <= FlushCount + CNT_W'(1);

            if (redirect && !PC_Write)
                Protocol_Err <= 1'b1;
            if (redirect && redirect_target[1:0] != 2'b00)
                Align_Err <= 1'b1;
            if (run_d == RUN_LIMIT)
                Stall_Timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Bench for fetch_stall_controller: directed test-plan sequences with literal expectations,
// then randomized traffic, all compared each cycle against a behavioural model.
module tb_fetch_stall_controller;

    localparam int          CNT_W     = 4;
    localparam int          MAX_STALL = 8;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          CNT_SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Stall, PC_Write, IF_ID_Write, PC_Src, Jump, JmpandLink, isJr;
    logic [31:0]      BranchTarget, JumpTarget, JrTarget, Instr_In;
    logic [31:0]      PC, IF_ID_Instr, IF_ID_PCPlus4;
    logic             IF_ID_Valid, ID_EXE_Valid;
    logic [1:0]       PipeState;
    logic [CNT_W-1:0] StallCycles, FlushCount;
    logic             Protocol_Err, Align_Err, Stall_Timeout;

    fetch_stall_controller #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Stall        (Stall),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .PC_Src       (PC_Src),
        .Jump         (Jump),
        .JmpandLink   (JmpandLink),
        .isJr         (isJr),
        .BranchTarget (BranchTarget),
        .JumpTarget   (JumpTarget),
        .JrTarget     (JrTarget),
        .Instr_In     (Instr_In),
        .PC           (PC),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid  (IF_ID_Valid),
        .ID_EXE_Valid (ID_EXE_Valid),
        .PipeState    (PipeState),
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount),
        .Protocol_Err (Protocol_Err),
        .Align_Err    (Align_Err),
        .Stall_Timeout(Stall_Timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: state names are plain integers 0..3 (FILL, RUN, STALL, FLUSH).
    bit          m_valid = 0;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_ifv, m_exv, m_perr, m_aerr, m_tout;
    int          m_state, m_stalls, m_flushes, m_run;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1;
            m_pc = RESET_PC; m_instr = 0; m_pc4 = 0;
            m_ifv = 0; m_exv = 0; m_perr = 0; m_aerr = 0; m_tout = 0;
            m_state = 0; m_stalls = 0; m_flushes = 0; m_run = 0;
        end else if (m_valid) begin
            bit          redir;
            logic [31:0] seq, tgt;
            redir = PC_Src || Jump || JmpandLink || isJr;
            seq   = m_pc + 32'd4;
            if (PC_Src)                  tgt = BranchTarget;
            else if (isJr)               tgt = JrTarget;
            else if (Jump || JmpandLink) tgt = JumpTarget;
            else                         tgt = seq;

            m_exv = m_ifv && !Stall;
            if (redir) begin
                m_instr = 0; m_ifv = 0;
            end else if (IF_ID_Write) begin
                m_instr = Instr_In; m_pc4 = seq; m_ifv = 1;
            end
            if (redir || PC_Write) m_pc = tgt & 32'hFFFF_FFFC;
            if (redir && (tgt % 4) != 0) m_aerr = 1;
            if (redir && !PC_Write) m_perr = 1;

            if (m_state == 0)   m_state = 1;
            else if (redir)     m_state = 3;
            else if (!PC_Write) m_state = 2;
            else                m_state = 1;

            if (!PC_Write && !redir) begin
                if (m_stalls < CNT_SAT) m_stalls++;
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run > MAX_STALL) m_tout = 1;
            if (redir && m_flushes < CNT_SAT) m_flushes++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc",     PC,            m_pc);
            check("model_instr",  IF_ID_Instr,   m_instr);
            check("model_pc4",    IF_ID_PCPlus4, m_pc4);
            check("model_ifv",    32'(IF_ID_Valid),   32'(m_ifv));
            check("model_exv",    32'(ID_EXE_Valid),  32'(m_exv));
            check("model_state",  32'(PipeState),     32'(m_state));
            check("model_stalls", 32'(StallCycles),   32'(m_stalls));
            check("model_flush",  32'(FlushCount),    32'(m_flushes));
            check("model_perr",   32'(Protocol_Err),  32'(m_perr));
            check("model_aerr",   32'(Align_Err),     32'(m_aerr));
            check("model_tout",   32'(Stall_Timeout), 32'(m_tout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Stall = 0; PC_Write = 1; IF_ID_Write = 1;
        PC_Src = 0; Jump = 0; JmpandLink = 0; isJr = 0;
    endtask

    task automatic hold(input logic stall_in);
        idle();
        Stall = stall_in; PC_Write = 0; IF_ID_Write = 0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        rst_n = 0; idle();
        BranchTarget = 0; JumpTarget = 0; JrTarget = 0; Instr_In = 32'h1111_0000;

        // Reset, then free run.
        tick();
        check("rst_pc", PC, 32'h0);
        check("rst_state", 32'(PipeState), 32'd0);
        check("rst_ifv", 32'(IF_ID_Valid), 32'd0);
        rst_n = 1; Instr_In = 32'h0000_00A0;
        tick();
        check("run_pc4", PC, 32'h4);
        check("run_state", 32'(PipeState), 32'd1);
        check("run_ifv", 32'(IF_ID_Valid), 32'd1);
        check("run_pcplus4", IF_ID_PCPlus4, 32'h4);
        tick(); tick();
        check("run_pc12", PC, 32'hC);
        Instr_In = 32'h8C22_0004;
        tick();
        check("run_pc16", PC, 32'h10);

        // Load-use stall at PC 0x10.
        hold(1); Instr_In = 32'hDEAD_BEEF;
        tick();
        check("lu_pc", PC, 32'h10);
        check("lu_instr", IF_ID_Instr, 32'h8C22_0004);
        check("lu_exv", 32'(ID_EXE_Valid), 32'd0);
        check("lu_stalls", 32'(StallCycles), 32'd1);
        check("lu_state", 32'(PipeState), 32'd2);

        // Taken branch with IF/ID held.
        idle(); IF_ID_Write = 0; PC_Src = 1; BranchTarget = 32'h40;
        tick();
        check("br_pc", PC, 32'h40);
        check("br_instr", IF_ID_Instr, 32'h0);
        check("br_ifv", 32'(IF_ID_Valid), 32'd0);
        check("br_flush", 32'(FlushCount), 32'd1);
        check("br_state", 32'(PipeState), 32'd3);

        // Priority and alignment.
        idle(); PC_Src = 1; isJr = 1; JrTarget = 32'h80; BranchTarget = 32'h40;
        tick();
        check("prio_pc", PC, 32'h40);
        check("prio_aerr", 32'(Align_Err), 32'd0);
        idle(); isJr = 1; JrTarget = 32'h82;
        tick();
        check("jr_pc", PC, 32'h80);
        check("jr_aerr", 32'(Align_Err), 32'd1);
        check("jr_flush", 32'(FlushCount), 32'd3);

        // Stall timeout on the ninth consecutive hold cycle.
        hold(1);
        repeat (8) tick();
        check("tout_8", 32'(Stall_Timeout), 32'd0);
        check("tout_pc", PC, 32'h80);
        tick();
        check("tout_9", 32'(Stall_Timeout), 32'd1);
        check("tout_stalls", 32'(StallCycles), 32'd10);

        // Redirect during PC_Write=0, then wrap from the top of memory.
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        tick();
        check("wrap_top", PC, 32'hFFFF_FFFC);
        check("perr", 32'(Protocol_Err), 32'd1);
        check("perr_stalls", 32'(StallCycles), 32'd10);
        idle(); Instr_In = 32'h2000_0001;
        tick();
        check("wrap_pc", PC, 32'h0);
        check("wrap_pcplus4", IF_ID_PCPlus4, 32'h0);

        // Stall counter saturates.
        hold(0); IF_ID_Write = 1;
        repeat (10) tick();
        check("sat_stalls", 32'(StallCycles), 32'(CNT_SAT));

        // Reset in the middle of a stall run.
        rst_n = 0;
        tick();
        check("mid_rst_pc", PC, RESET_PC);
        check("mid_rst_stalls", 32'(StallCycles), 32'd0);
        check("mid_rst_flush", 32'(FlushCount), 32'd0);
        check("mid_rst_flags", {29'd0, Protocol_Err, Align_Err, Stall_Timeout}, 32'd0);
        check("mid_rst_state", 32'(PipeState), 32'd0);
        rst_n = 1; idle();

        // Randomized traffic with occasional long hold bursts and resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int burst;
            rst_n = ($urandom_range(0, 299) != 0);
            idle();
            if (cyc % 400 == 100) burst = $urandom_range(5, 14);
            if (burst > 0) begin
                burst--;
                hold(1'($urandom));
            end else begin
                Stall       = ($urandom_range(0, 4) == 0);
                PC_Write    = ($urandom_range(0, 3) != 0);
                IF_ID_Write = ($urandom_range(0, 3) != 0) ? PC_Write : 1'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    PC_Src     = 1'($urandom);
                    Jump       = 1'($urandom);
                    JmpandLink = 1'($urandom);
                    isJr       = 1'($urandom);
                end
            end
            BranchTarget = rand_target();
            JumpTarget   = rand_target();
            JrTarget     = rand_target();
            Instr_In     = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stall_controller.md
Name: fetch_stall_controller

Overview:
Consumer of the hazard-detection control interface (Stall, PC_Write, IF_ID_Write, PC_Src, Jump, JmpandLink, isJr). Owns the PC register, the IF/ID pipeline register and the ID/EX valid bit, and applies hold, flush and bubble decisions cycle by cycle. It also maintains a small pipeline-state FSM, stall and flush counters, and sticky protocol and error flags for debug and verification.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the saturating stall and flush counters.
MAX_STALL, 8, longest permitted run of consecutive PC_Write=0 cycles before Stall_Timeout is set.

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
Stall  input  1  hazard unit: squash the instruction entering ID/EX.
PC_Write  input  1  hazard unit: 1 = update PC, 0 = hold PC.
IF_ID_Write  input  1  hazard unit: 1 = load IF/ID, 0 = hold IF/ID.
PC_Src  input  1  branch taken (resolved in ID).
Jump  input  1  j instruction in ID.
JmpandLink  input  1  jal instruction in ID.
isJr  input  1  jr instruction in ID.
BranchTarget  input  32  branch target address.
JumpTarget  input  32  j/jal target address.
JrTarget  input  32  jr register target address.
Instr_In  input  32  instruction memory read data at PC.
PC  output  32  current fetch address.
IF_ID_Instr  output  32  latched instruction (NOP = 32'h0).
IF_ID_PCPlus4  output  32  latched PC+4.
IF_ID_Valid  output  1  IF/ID holds a real instruction.
ID_EXE_Valid  output  1  the instruction now in ID/EX is real (not a bubble).
PipeState  output  2  0 FILL, 1 RUN, 2 STALL, 3 FLUSH.
StallCycles  output  CNT_W  count of cycles with PC_Write=0 (saturating).
FlushCount  output  CNT_W  count of redirect cycles (saturating).
Protocol_Err  output  1  sticky flag: a redirect arrived with PC_Write=0.
Align_Err  output  1  sticky flag: a selected target had bits [1:0] != 0.
Stall_Timeout  output  1  sticky flag: stall run exceeded MAX_STALL.

Behaviour:
- Reset (rst_n=0 at posedge, which overrides everything): PC=RESET_PC, IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, ID_EXE_Valid=0, PipeState=FILL, both counters 0, all sticky flags 0, internal stall-run counter 0. A reset asserted mid-stall or mid-flush discards all in-flight state.
- redirect = PC_Src | Jump | JmpandLink | isJr.
- Next-PC priority: PC_Src -> BranchTarget; else isJr -> JrTarget; else (Jump|JmpandLink) -> JumpTarget; else PC+4. PC+4 wraps modulo 2^32.
- Bits [1:0] of the loaded PC are forced to 00. A selected target with nonzero [1:0] sets Align_Err.
- PC updates when PC_Write=1 or when redirect=1. Redirect takes priority over PC_Write=0; if both occur, Protocol_Err is set.
- IF/ID update, in priority order:
  - redirect: IF_ID_Instr <= 0 and IF_ID_Valid <= 0 (flush), even though IF_ID_Write=0.
  - else IF_ID_Write=1: IF_ID_Instr <= Instr_In, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
  - else: hold all IF/ID contents.
- ID_EXE_Valid <= IF_ID_Valid & ~Stall, updated every cycle. A stalled or flushed ID stage therefore produces a bubble one cycle later.
- FSM, evaluated every cycle:
  - FILL -> RUN after exactly one cycle.
  - From any non-FILL state: redirect -> FLUSH; else PC_Write=0 -> STALL; else RUN.
  - Latency: PipeState reflects the previous cycle's decision.
- StallCycles increments on every cycle with PC_Write=0 and no redirect. FlushCount increments on every redirect cycle. Both saturate at 2^CNT_W-1 and never wrap.
- The stall-run counter increments on each consecutive cycle with PC_Write=0 and no redirect, and clears otherwise. When it reaches MAX_STALL+1, Stall_Timeout is set.
- Sticky flags clear only on reset.
- Back-to-back redirects each flush IF/ID and each count once. A load-use stall immediately after a flush holds the flushed NOP with IF_ID_Valid=0.

Test Plan:
- Reset then free-run, all controls idle, PC_Write=1, IF_ID_Write=1 -> PC steps 0,4,8,12. IF_ID_Valid=1 from cycle 2. PipeState goes FILL then RUN.
- Load-use: Stall=1, PC_Write=0, IF_ID_Write=0 for 1 cycle at PC=0x10 -> PC holds 0x10, IF/ID holds, ID_EXE_Valid=0 next cycle, StallCycles=1, PipeState=STALL.
- Branch: PC_Src=1, BranchTarget=0x40, IF_ID_Write=0 -> PC=0x40, IF_ID_Instr=0, IF_ID_Valid=0, FlushCount=1, PipeState=FLUSH.
- Priority: PC_Src=1 and isJr=1 together, JrTarget=0x80, BranchTarget=0x40 -> PC=0x40. Then isJr alone with JrTarget=0x82 -> PC=0x80 and Align_Err=1.
- PC_Write=0 held 9 cycles with MAX_STALL=8 -> Stall_Timeout=1 on the 9th cycle. PC=0xFFFF_FFFC then free run -> PC=0.
- Assert rst_n=0 during a stall run -> all outputs return to their reset values on the next edge, and the counters and flags clear.
